// File: rtl/uart_hex_logger_if.sv
// uart_hex_logger_if: producer channels plus AXI4-Lite write channel between the logger and UART-Lite.
// master = logger side, slave = producers/UART side.
interface uart_hex_logger_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 16
);
   logic [NUM_CH*DATA_W-1:0] data;
   logic [NUM_CH-1:0]        valid;
   logic [NUM_CH-1:0]        ready;
   logic [3:0]               awaddr;
   logic                     awvalid;
   logic                     awready;
   logic [7:0]               wdata;
   logic                     wvalid;
   logic                     wready;
   logic [1:0]               bresp;
   logic                     bvalid;
   logic                     bready;
   modport master (
      input  data, valid, awready, wready, bresp, bvalid,
      output ready, awaddr, awvalid, wdata, wvalid, bready
   );
   modport slave (
      output data, valid, awready, wready, bresp, bvalid,
      input  ready, awaddr, awvalid, wdata, wvalid, bready
   );
endinterface

// File: rtl/uart_hex_logger.sv
// uart_hex_logger: round-robin multi-channel word printer (uppercase hex + LF CR) over AXI4-Lite UART-Lite.
// Define UART_HEX_LOGGER_CH_TAG_EN to prefix every record with "<channel hex digit>:".
module uart_hex_logger #(
   parameter int         DATA_W    = 16,
   parameter int         NUM_CH    = 2,
   parameter logic [7:0] CTRL_WORD = 8'h03
) (
   input  logic              clk,
   input  logic              rst,
   uart_hex_logger_if.master bus,
   output logic              busy,
   output logic [7:0]        err_cnt
);
`ifdef UART_HEX_LOGGER_CH_TAG_EN
   localparam int TAG = 2;
`else
   localparam int TAG = 0;
`endif
   localparam int ND = DATA_W / 4;
   localparam int NREC = TAG + ND + 2;
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int IW = $clog2(NREC);
   localparam logic [IW-1:0] LAST = IW'(NREC - 1);
   typedef enum logic [2:0] {INIT_WR, INIT_RESP, IDLE, CHAR_WR, CHAR_RESP} state_t;
   state_t state, state_n;
   logic aw_done, w_done, aw_done_n, w_done_n;
   logic awvalid, wvalid, bready, awvalid_n, wvalid_n, bready_n;
   logic [3:0] awaddr, awaddr_n;
   logic [7:0] wdata, wdata_n, err_n;
   logic [DATA_W-1:0] word, word_n;
   logic [CW-1:0] ch, ch_n, last_grant, lg_n, grant;
   logic [IW-1:0] idx, idx_n;
   logic any;
   function automatic logic [7:0] hex(input logic [3:0] n);
      return n < 4'd10 ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
   endfunction
   // Character i of a record: optional tag, digits MS nibble first, then LF, CR
   function automatic logic [7:0] chr_of(input logic [DATA_W-1:0] w, input logic [CW-1:0] c, input logic [IW-1:0] i);
      int d;
      d = int'(i) - TAG;
      return (TAG != 0 && int'(i) == 0) ? hex(4'(c)) : (TAG != 0 && int'(i) == 1) ? 8'h3A :
             d == ND ? 8'h0A : d == ND + 1 ? 8'h0D : hex(4'(w >> (4 * (ND - 1 - d))));
   endfunction
   // Lowest k wins: first valid channel after last_grant
   always_comb begin
      grant = last_grant;
      any = 1'b0;
      for (int k = NUM_CH; k >= 1; k--) begin
         if (bus.valid[CW'((int'(last_grant) + k) % NUM_CH)]) begin
            grant = CW'((int'(last_grant) + k) % NUM_CH);
            any = 1'b1;
         end
      end
   end
   always_comb begin
      state_n = state;
      aw_done_n = aw_done;
      w_done_n = w_done;
      awvalid_n = awvalid;
      wvalid_n = wvalid;
      bready_n = bready;
      err_n = err_cnt;
      word_n = word;
      ch_n = ch;
      idx_n = idx;
      lg_n = last_grant;
      if (state == INIT_WR || state == CHAR_WR) begin
         aw_done_n = aw_done | (awvalid & bus.awready);
         w_done_n = w_done | (wvalid & bus.wready);
         awvalid_n = !aw_done_n;
         wvalid_n = !w_done_n;
         if (aw_done_n && w_done_n) begin
            state_n = state == INIT_WR ? INIT_RESP : CHAR_RESP;
            {aw_done_n, w_done_n, bready_n} = 3'b001;
         end
      end else if ((state == INIT_RESP || state == CHAR_RESP) && bus.bvalid) begin
         bready_n = 1'b0;
         if (bus.bresp != 2'b00) begin
            err_n = err_cnt == 8'hFF ? err_cnt : err_cnt + 8'd1;
            state_n = state == INIT_RESP ? INIT_WR : CHAR_WR;
         end else if (state == CHAR_RESP && idx != LAST) begin
            idx_n = idx + 1'b1;
            state_n = CHAR_WR;
         end else begin
            state_n = IDLE;
            lg_n = state == CHAR_RESP ? ch : last_grant;
         end
         {awvalid_n, wvalid_n} = {2{state_n != IDLE}};
      end else if (state == IDLE && any) begin
         word_n = DATA_W'(bus.data >> (int'(grant) * DATA_W));
         ch_n = grant;
         idx_n = '0;
         state_n = CHAR_WR;
         {awvalid_n, wvalid_n} = 2'b11;
      end
      awaddr_n = state_n == INIT_WR ? 4'hC : state_n == CHAR_WR ? 4'h4 : awaddr;
      wdata_n = state_n == INIT_WR ? CTRL_WORD : state_n == CHAR_WR ? chr_of(word_n, ch_n, idx_n) : wdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT_WR;
         {aw_done, w_done, awvalid, wvalid, bready} <= '0;
         awaddr <= '0;
         wdata <= '0;
         err_cnt <= '0;
         word <= '0;
         ch <= '0;
         idx <= '0;
         last_grant <= CW'(NUM_CH - 1);
      end else begin
         state <= state_n;
         {aw_done, w_done, awvalid, wvalid, bready} <= {aw_done_n, w_done_n, awvalid_n, wvalid_n, bready_n};
         awaddr <= awaddr_n;
         wdata <= wdata_n;
         err_cnt <= err_n;
         word <= word_n;
         ch <= ch_n;
         idx <= idx_n;
         last_grant <= lg_n;
      end
   end
   assign bus.ready = (state == IDLE && any) ? NUM_CH'(1) << grant : '0;
   assign bus.awvalid = awvalid;
   assign bus.wvalid = wvalid;
   assign bus.bready = bready;
   assign bus.awaddr = awaddr;
   assign bus.wdata = wdata;
   assign busy = state != IDLE;
endmodule

// File: tb/tb_uart_hex_logger.sv
// tb_uart_hex_logger: random producers and a random-latency, error-injecting UART-Lite slave,
// checked against a record/arbitration reference model.
module tb_uart_hex_logger;
   localparam int DATA_W = 16;
   localparam int NUM_CH = 2;
   localparam int ND = DATA_W / 4;
`ifdef UART_HEX_LOGGER_CH_TAG_EN
   localparam int NREC = ND + 4;
`else
   localparam int NREC = ND + 2;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic [7:0] err_cnt;
   uart_hex_logger_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus();
   uart_hex_logger #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_WORD(8'h03)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_cnt(err_cnt)
   );
   always #5 clk = ~clk;
   int passed = 0;
   int total = 0;
   logic [DATA_W-1:0] word [NUM_CH];
   logic [NUM_CH-1:0] vld;
   byte unsigned exp_q[$];
   int lg, err_exp, errpct, prodpct, resp_dly;
   bit init_done, got_aw, got_w, resp_on, resp_err, hold, drop_ok;
   logic [3:0] aw_a;
   logic [7:0] w_d;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic byte unsigned hexc(int n);
      return n < 10 ? byte'(48 + n) : byte'(65 + n - 10);
   endfunction
   task automatic push_record(int c, logic [DATA_W-1:0] w);
`ifdef UART_HEX_LOGGER_CH_TAG_EN
      exp_q.push_back(hexc(c));
      exp_q.push_back(8'h3A);
`endif
      for (int d = ND - 1; d >= 0; d--) exp_q.push_back(hexc(int'((w >> (4 * d)) & 15)));
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0D);
   endtask
   task automatic model_reset();
      exp_q.delete();
      {init_done, got_aw, got_w, resp_on, resp_err} = '0;
      resp_dly = 0;
      err_exp = 0;
      lg = NUM_CH - 1;
      vld = '0;
   endtask
   task automatic drive();
      for (int i = 0; i < NUM_CH; i++) begin
         if (!vld[i] && $urandom_range(99) < prodpct) begin
            vld[i] = 1'b1;
            word[i] = DATA_W'($urandom);
         end else if (vld[i] && drop_ok && $urandom_range(15) == 0) vld[i] = 1'b0;
         bus.data[i*DATA_W +: DATA_W] = word[i];
      end
      bus.valid = vld;
      bus.awready = $urandom_range(3) != 0;
      bus.wready = $urandom_range(3) != 0;
      bus.bvalid = resp_on && resp_dly == 0;
      if (resp_on && resp_dly > 0) resp_dly--;
      bus.bresp = resp_err ? 2'b10 : 2'b00;
   endtask
   task automatic sample();
      bit idle;
      int ec;
      idle = init_done && exp_q.size() == 0;
      ec = -1;
      for (int k = 1; k <= NUM_CH; k++) if (vld[(lg + k) % NUM_CH]) begin ec = (lg + k) % NUM_CH; break; end
      check("busy", busy, !idle);
      check("ready", bus.ready, (idle && ec >= 0) ? 64'(1) << ec : 64'd0);
      check("bready", bus.bready, resp_on);
      check("err_cnt", err_cnt, err_exp);
      if (got_aw) check("awvalid_drop", bus.awvalid, 0);
      if (got_w) check("wvalid_drop", bus.wvalid, 0);
      for (int i = 0; i < NUM_CH; i++) if (vld[i] && bus.ready[i]) begin
         push_record(i, word[i]);
         lg = i;
         vld[i] = hold;
      end
      if (bus.awvalid && bus.awready) begin got_aw = 1; aw_a = bus.awaddr; end
      if (bus.wvalid && bus.wready) begin got_w = 1; w_d = bus.wdata; end
      if (bus.bvalid && bus.bready) begin
         if (bus.bresp != 2'b00) err_exp = err_exp < 255 ? err_exp + 1 : 255;
         else if (!init_done) begin
            check("init_addr", aw_a, 4'hC);
            check("init_data", w_d, 8'h03);
            init_done = 1;
         end else begin
            check("char_addr", aw_a, 4'h4);
            check("char_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("char_data", w_d, exp_q.pop_front());
         end
         {got_aw, got_w, resp_on} = '0;
      end
      if (got_aw && got_w && !resp_on) begin
         resp_on = 1;
         resp_dly = $urandom_range(2);
         resp_err = $urandom_range(99) < errpct;
      end
   endtask
   task automatic cycle();
      @(negedge clk);
      drive();
      #1;
      sample();
   endtask
   task automatic check_rst();
      check("rst_awvalid", bus.awvalid, 0);
      check("rst_wvalid", bus.wvalid, 0);
      check("rst_bready", bus.bready, 0);
      check("rst_awaddr", bus.awaddr, 0);
      check("rst_wdata", bus.wdata, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_ready", bus.ready, 0);
      check("rst_busy", busy, 1);
   endtask
   task automatic check_first_aw();
      check("first_awvalid", bus.awvalid, 1);
      check("first_awaddr", bus.awaddr, 4'hC);
      check("first_wdata", bus.wdata, 8'h03);
   endtask
   task automatic drain(string tag);
      int n = 0;
      prodpct = 0;
      hold = 0;
      drop_ok = 0;
      while (n < 3000 && !(init_done && exp_q.size() == 0 && vld == '0)) begin cycle(); n++; end
      check(tag, {init_done, exp_q.size() == 0, vld == '0}, 3'b111);
      repeat (2) cycle();
   endtask
   initial begin
      for (int i = 0; i < NUM_CH; i++) word[i] = '0;
      {prodpct, errpct, hold, drop_ok} = '0;
      model_reset();
      vld = '1;
      drive();
      #1;
      check_rst();
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      check_first_aw();
      drain("drain_init");
      // random traffic with split handshakes, valid drops and error retries
      prodpct = 30;
      errpct = 10;
      drop_ok = 1;
      repeat (2500) cycle();
      drain("drain_random");
      errpct = 0;
      vld[0] = 1'b1;
      word[0] = 16'h3A7F;
      drain("drain_3a7f");
      vld = '1;
      word[0] = 16'h0001;
      word[1] = 16'hFFFF;
      hold = 1;
      repeat (40) cycle();
      drain("drain_rr");
      vld[0] = 1'b1;
      word[0] = 16'h1234;
      begin
         int n = 0;
         while (n < 300 && !(init_done && exp_q.size() == NREC - 2 && bus.awvalid)) begin cycle(); n++; end
         check("mid_reached", n < 300, 1);
      end
      rst = 1'b1;
      #1;
      check_rst();
      model_reset();
      errpct = 100;
      repeat (2) cycle();
      rst = 1'b0;
      cycle();
      check_first_aw();
      begin
         int n = 0;
         while (n < 8000 && err_exp < 255) begin cycle(); n++; end
      end
      repeat (20) cycle();
      check("err_sat", err_cnt, 8'hFF);
      errpct = 0;
      drain("drain_final");
      check("err_hold", err_cnt, 8'hFF);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
